// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder for the CPU load/store port
//
// Accepts one load/store request at a time over a valid/ready handshake,
// waits WAIT_STATES extra cycles, performs a byte/halfword/word access on an
// internal word array and returns a one-cycle response pulse.
//
// Optional build macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses are rejected with rsp_err
//   undefined - misaligned low address bits are ignored
//
// Parameters:
//   ADDR_W       request address width
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra busy cycles per access (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request this cycle
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_size   in   access size, RV32I funct3 encoding
//   req_wdata  in   store data (low byte/halfword for sub-word stores)
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  extended load result; 0 for stores and errors
//   rsp_err    out  access rejected, qualified by rsp_valid

module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // First byte address past the end of the array, one bit wider than the
  // address so the compare cannot overflow.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [AW-1:0]     word_idx;
  logic [1:0]        lane;
  logic [31:0]       mem_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              out_of_range;
  logic              size_bad;
  logic              misalign;
  logic              acc_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              access_fire;
  logic              mem_we;

  // Ready is forced low while reset is held, not just after the state clears.
  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  assign word_idx     = addr_q[AW+1:2];
  assign lane         = addr_q[1:0];
  assign mem_word     = mem[word_idx];
  assign byte_sel     = mem_word[{lane, 3'b000} +: 8];
  assign half_sel     = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
  assign out_of_range = ({1'b0, addr_q} >= LIMIT);

  // Unsigned load codes have no store counterpart.
  always_comb begin
    size_bad = 1'b1;
    case (size_q)
      3'b000, 3'b001, 3'b010: size_bad = 1'b0;
      3'b100, 3'b101:         size_bad = wr_q;
      default:                size_bad = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (size_q[1:0] == 2'b01 && addr_q[0])
      misalign = 1'b1;
    else if (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00)
      misalign = 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = out_of_range || size_bad || misalign;

  always_comb begin
    load_data = mem_word;
    case (size_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase
  end

  // Read-modify-write merge: only the addressed lanes change.
  always_comb begin
    store_word = mem_word;
    case (size_q[1:0])
      2'b00:   store_word[{lane, 3'b000} +: 8]       = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  assign access_fire = (state == BUSY) && (cnt == 4'd0);
  // Gated by rst so a store whose access edge coincides with reset is dropped.
  assign mem_we      = access_fire && wr_q && !acc_err && !rst;

  // Array contents are never reset, so the write port lives outside the
  // reset domain.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[word_idx] <= store_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 3'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            cnt     <= 4'(WAIT_STATES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || wr_q) ? 32'd0 : load_data;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_0, req_ready_0, req_write_0;
  logic [31:0] req_addr_0;
  logic [2:0]  req_size_0;
  logic [31:0] req_wdata_0;
  logic        rsp_valid_0, rsp_err_0;
  logic [31:0] rsp_rdata_0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_write(req_write_0),
    .req_addr(req_addr_0), .req_size(req_size_0), .req_wdata(req_wdata_0),
    .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
  );

  // Drives one request on dut and waits for its response; called at #1 after an edge.
  // lat = edges from acceptance to the first sample showing rsp_valid.
  task automatic access(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat, output logic ready_hi, output logic after_v);
    int guard;
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; ready_hi = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (req_ready) ready_hi = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (req_ready) ready_hi = 1'b1;
    if (lat >= 50) begin
      total++; bad++;
      $display("FAIL rsp_timeout addr=%h", a);
    end
    rd = rsp_rdata; e = rsp_err;
    @(posedge clk); #1;
    after_v = rsp_valid;
  endtask

  task automatic test_reset;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_first_response;
    logic [31:0] rd; logic e, rh, av; int lat;
    access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, e, lat, rh, av);
    total++; if (lat != 3) begin bad++; $display("FAIL first_latency got=%0d exp=3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL first_err got=%b exp=0", e); end
    total++; if (rh !== 1'b0) begin bad++; $display("FAIL first_ready_busy got=%b exp=0", rh); end
    total++; if (av !== 1'b0) begin bad++; $display("FAIL first_pulse_width got=%b exp=0", av); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL first_store_rdata got=%h exp=0", rd); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic e, rh, av; int lat;
    access(1'b1, 32'h11, 3'b000, 32'h00000080, rd, e, lat, rh, av);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", e); end
    access(1'b0, 32'h10, 3'b010, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL lw_after_sb got=%h exp=DEAD80EF", rd); end
    access(1'b0, 32'h11, 3'b000, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=FFFFFF80", rd); end
    access(1'b0, 32'h11, 3'b100, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
    access(1'b0, 32'h12, 3'b101, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL lhu got=%h exp=0000DEAD", rd); end
    access(1'b0, 32'h12, 3'b001, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh got=%h exp=FFFFDEAD", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e, rh, av; int lat;
    access(1'b1, 32'h0, 3'b010, 32'h0BADF00D, rd, e, lat, rh, av);
    access(1'b1, 32'h1000, 3'b010, 32'h11111111, rd, e, lat, rh, av);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", e); end
    access(1'b0, 32'h0, 3'b010, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL no_alias got=%h exp=0BADF00D", rd); end
    access(1'b0, 32'h10, 3'b011, 32'h0, rd, e, lat, rh, av);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL size011_err got=%b exp=1", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL size011_rdata got=%h exp=0", rd); end
    access(1'b1, 32'h10, 3'b100, 32'h00000055, rd, e, lat, rh, av);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL store_u_err got=%b exp=1", e); end
    access(1'b0, 32'h10, 3'b010, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL store_u_nowrite got=%h exp=DEAD80EF", rd); end
    access(1'b1, 32'hFFC, 3'b010, 32'h5A5A5A5A, rd, e, lat, rh, av);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL last_word_err got=%b exp=0", e); end
    access(1'b0, 32'hFFC, 3'b010, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL last_word_rd got=%h exp=5A5A5A5A", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic e, rh, av; int lat;
    access(1'b0, 32'h12, 3'b010, 32'h0, rd, e, lat, rh, av);
`ifdef DMEM_MISALIGN_TRAP_EN
    total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b exp=1", e); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
`else
    total++; if (e !== 1'b0) begin bad++; $display("FAIL misalign_err got=%b exp=0", e); end
    total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL misalign_rdata got=%h exp=DEAD80EF", rd); end
`endif
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] rd; logic e, rh, av; int lat;
    logic seen;
    access(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, rd, e, lat, rh, av);
    req_write = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL aborted_rsp got=%b exp=0", seen); end
    access(1'b0, 32'h20, 3'b010, 32'h0, rd, e, lat, rh, av);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL aborted_store got=%h exp=CAFEF00D", rd); end
  endtask

  task automatic test_held_valid;
    int accepts, first_i, second_i, pulses;
    accepts = 0; first_i = -1; second_i = -1; pulses = 0;
    req_write_0 = 1'b0; req_addr_0 = 32'h4; req_size_0 = 3'b010; req_wdata_0 = 32'h0;
    req_valid_0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (req_ready_0) begin
        if (accepts == 0) first_i = i; else if (accepts == 1) second_i = i;
        accepts++;
      end
      @(posedge clk); #1;
      if (rsp_valid_0) pulses++;
    end
    req_valid_0 = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid_0) pulses++; end
    total++; if (accepts != 2) begin bad++; $display("FAIL held_accepts got=%0d exp=2", accepts); end
    total++; if (second_i - first_i != 3) begin bad++; $display("FAIL held_spacing got=%0d exp=3", second_i - first_i); end
    total++; if (pulses != 2) begin bad++; $display("FAIL held_rsp_cycles got=%0d exp=2", pulses); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 3'b0; req_wdata = 32'h0;
    req_valid_0 = 1'b0; req_write_0 = 1'b0; req_addr_0 = 32'h0; req_size_0 = 3'b0; req_wdata_0 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_first_response;
    test_subword;
    test_errors;
    test_misalign;
    test_reset_mid_busy;
    test_held_valid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Wait-stated data-memory responder that serves the CPU's load/store port: it accepts one request at a time over a valid/ready handshake, performs a byte/halfword/word access on an internal word array, and returns a one-cycle response pulse. It sits between the pipeline's MEM-stage access logic and on-chip data RAM. It models slower memory so stall and handshake behaviour can be exercised ahead of an external bus.

## Interface
- `ADDR_W`, 32: request address width.
- `DEPTH_WORDS`, 1024: number of 32-bit words, power of two, ≥ 4.
- `WAIT_STATES`, 2: extra busy cycles per access, 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_size`  in  3  access size in RV32I funct3 encoding.
- `req_wdata`  in  32  store data; the low byte or halfword is used for sub-word stores.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result, already extended; 0 for stores and errors.
- `rsp_err`  out  1  access rejected; qualified by `rsp_valid`.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **Outputs by state:**
  - `req_ready` = (state == IDLE) and not `rst`.
  - `rsp_valid` = (state == RESP).
- **IDLE:** a handshake (`req_valid` and `req_ready`) registers write, addr, size and wdata, and loads `cnt` with `WAIT_STATES`. Next state is BUSY. Inputs are ignored when no handshake occurs.
- **BUSY:**
  - If `cnt` ≠ 0: decrement `cnt` and stay in BUSY.
  - If `cnt` = 0: perform the access, register `rsp_rdata` and `rsp_err`, and go to RESP.
- **RESP:** unconditionally return to IDLE on the next edge. There is no backpressure on the response.
- **Size decode:**
  - 000 signed byte
  - 001 signed halfword
  - 010 word
  - 100 unsigned byte
  - 101 unsigned halfword
  - Any other code sets `rsp_err`.
  - For stores, 000, 001 and 010 are legal; store codes 100 and 101 set `rsp_err`.
- **Lanes:** little-endian.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Sub-word stores modify only the selected lanes.
- **Range check:** an address ≥ 4·`DEPTH_WORDS` sets `rsp_err`.
- **Error responses:** no array write, and `rsp_rdata` = 0.
- **Register hold:** `rsp_rdata` and `rsp_err` keep their value until the next access completes.

## Timing
- **Reset values:** state = IDLE, `cnt` = 0, `req_ready` = 0 while `rst` is high, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. Array contents are not reset.
- **Latency:** for a request accepted at edge k, the access occurs at edge k+1+`WAIT_STATES`, and `rsp_valid` is high for exactly the cycle after that edge.
- **Throughput:** one request per `WAIT_STATES`+3 cycles. `req_ready` is low throughout BUSY and RESP.
- **Store visibility:** a store takes effect at its access edge, so a following load observes it.
- **Reset mid-operation:** `rst` in BUSY or RESP aborts the transaction. A store whose access edge has not yet occurred is dropped, and no response is issued.
- **Handshake rule:** `req_valid` may be held across BUSY and RESP. It is accepted only once the responder returns to IDLE.

## Configuration
- **Macro:** `DMEM_MISALIGN_TRAP_EN`.
- **Defined:** a halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, sets `rsp_err`, suppresses the write and returns `rsp_rdata` = 0.
- **Undefined:** misaligned low address bits are ignored, with halfwords using addr[1] and words using addr[1:0] = 00. Misalignment never sets `rsp_err`.

## Test plan
- **Reset and first response** (`WAIT_STATES`=2): release `rst`, then store word 0xDEADBEEF at 0x10 accepted at edge k. Required: `rsp_valid` only in the cycle after edge k+3, `rsp_err` = 0, `req_ready` low between acceptance and that cycle.
- **Sub-word stores and extending loads:**
  - Store byte 0x80 at 0x11 over 0xDEADBEEF, then load word at 0x10. Required: 0xDEAD80EF.
  - Load size 000 at 0x11. Required: 0xFFFFFF80.
  - Load size 100 at 0x11. Required: 0x00000080.
  - Load size 101 at 0x12. Required: 0x0000DEAD.
- **Errors** (`DEPTH_WORDS`=1024):
  - Store at 0x1000. Required: `rsp_err` = 1, and a later load at 0x0 shows no aliasing write.
  - Load with size 011. Required: `rsp_err` = 1, `rsp_rdata` = 0.
- **Misalignment:** word load at 0x12.
  - With the macro: `rsp_err` = 1.
  - Without it: `rsp_err` = 0 and the word at 0x10 is returned.
- **Reset mid-BUSY:** assert `rst` one cycle after accepting a store to 0x20 of 0x12345678, then read 0x20. Required: the previous contents are unchanged and no `rsp_valid` pulse for the aborted request.
- **Held valid** (`WAIT_STATES`=0): keep `req_valid` high for 6 cycles with fixed fields. Required: exactly 2 acceptances, 3 cycles apart, each followed by a single `rsp_valid` pulse.
